muldiv_sched: RTL and testbench

- Sequencer between the execute stage and the shared iterative multiply / divide units.
- Accepts one M-extension op at a time and prepares operands, including RV64 word-op extension.
- Resolves divide-by-zero and signed-overflow cases without starting a unit; otherwise starts the correct unit and waits for its done.
- Folds the unit result to the architectural value and holds it under a valid/ready handshake; supports pipeline flush and a watchdog.

---
 rtl/muldiv_sched_if.sv | 24 ++
 rtl/muldiv_sched.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sched.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Request/response handshake between the execute stage and the M-extension sequencer.
// The execute stage is the master; muldiv_sched is the slave.
interface muldiv_sched_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic        req_word;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_data;
   logic        resp_err;

   modport master (
      output req_valid, req_op, req_word, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_err
   );

   modport slave (
      input  req_valid, req_op, req_word, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_err
   );
endinterface

// File: rtl/muldiv_sched.sv
// Sequencer between execute and the shared iterative multiplier/divider: prepares operands,
// resolves divide corner cases locally, waits for the unit and folds its result.
module muldiv_sched #(
   parameter int MAX_CYCLES = 80,
   parameter int LAT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   muldiv_sched_if.slave    bus,
   output logic             stall,
   output logic             mul_start,
   input  logic             mul_done,
   input  logic [63:0]      mul_result,
   output logic             div_start,
   output logic             div_signed,
   input  logic             div_done,
   input  logic [63:0]      div_quot,
   input  logic [63:0]      div_rem,
   output logic [63:0]      unit_a,
   output logic [63:0]      unit_b,
   output logic             unit_kill,
   output logic [LAT_W-1:0] last_lat
);

   localparam logic [2:0]  OP_MUL   = 3'd0;
   localparam logic [2:0]  OP_DIV   = 3'd1;
   localparam logic [2:0]  OP_DIVU  = 3'd2;
   localparam logic [2:0]  OP_REM   = 3'd3;
   localparam logic [2:0]  OP_REMU  = 3'd4;
   localparam int          CNT_W    = $clog2(MAX_CYCLES + 1);
   localparam longint      LAT_MAX  = (64'sd1 <<< LAT_W) - 64'sd1;
   localparam logic [63:0] ALL_ONES = {64{1'b1}};
   localparam logic [63:0] MIN_D    = 64'h8000_0000_0000_0000;
   localparam logic [63:0] MIN_W    = 64'hFFFF_FFFF_8000_0000;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   state_t           state, state_nxt;
   logic [2:0]       op_q;
   logic             word_q;
   logic [CNT_W-1:0] cnt;

   logic             in_div, in_signed, in_rem, in_rsvd;
   logic [63:0]      prep_a, prep_b, fast_raw, unit_raw;
   logic             div_by_zero, overflow, fast_hit, sel_done;
   logic             accept, take, timeout;

   function automatic logic [63:0] fold(input logic word, input logic [63:0] r);
      return word ? {{32{r[31]}}, r[31:0]} : r;
   endfunction

   assign in_div    = bus.req_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   assign in_signed = bus.req_op inside {OP_DIV, OP_REM};
   assign in_rem    = bus.req_op inside {OP_REM, OP_REMU};
   assign in_rsvd   = bus.req_op > OP_REMU;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      prep_a = bus.req_a;
      prep_b = bus.req_b;
      if (bus.req_word && in_div) begin
         if (in_signed) begin
            prep_a = {{32{bus.req_a[31]}}, bus.req_a[31:0]};
            prep_b = {{32{bus.req_b[31]}}, bus.req_b[31:0]};
         end else begin
            prep_a = {32'd0, bus.req_a[31:0]};
            prep_b = {32'd0, bus.req_b[31:0]};
         end
      end
   end

   // Divide-by-zero and signed overflow have architecturally fixed answers; no unit needed.
   assign div_by_zero = in_div && (prep_b == 64'd0);
   assign overflow    = in_signed && (prep_a == (bus.req_word ? MIN_W : MIN_D)) &&
                        (prep_b == ALL_ONES);
   assign fast_hit    = div_by_zero || overflow;
   assign fast_raw    = in_rem ? (div_by_zero ? prep_a : 64'd0)
                               : (div_by_zero ? ALL_ONES : prep_a);

   assign unit_raw = (op_q == OP_MUL) ? mul_result
                   : ((op_q inside {OP_REM, OP_REMU}) ? div_rem : div_quot);
   assign sel_done = (op_q == OP_MUL) ? mul_done : div_done;

   assign bus.req_ready  = (state == S_IDLE) && !flush;
   assign bus.resp_valid = (state == S_DONE);
   assign stall          = bus.req_valid && !((state == S_DONE) && bus.resp_ready);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      take      = 1'b0;
      timeout   = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req_valid && bus.req_ready) begin
               accept    = 1'b1;
               state_nxt = (in_rsvd || fast_hit) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            // The unit cannot answer in the cycle it is started, so cnt == 1 masks done.
            if ((cnt != CNT_W'(1)) && sel_done) begin
               take      = 1'b1;
               state_nxt = S_DONE;
            end else if (cnt == CNT_W'(MAX_CYCLES)) begin
               timeout   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      if (flush) begin
         state_nxt = S_IDLE;
         take      = 1'b0;
         timeout   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q          <= 3'd0;
         word_q        <= 1'b0;
         cnt           <= '0;
         unit_a        <= 64'd0;
         unit_b        <= 64'd0;
         div_signed    <= 1'b0;
         mul_start     <= 1'b0;
         div_start     <= 1'b0;
         unit_kill     <= 1'b0;
         bus.resp_data <= 64'd0;
         bus.resp_err  <= 1'b0;
         last_lat      <= '0;
      end else begin
         mul_start <= accept && !in_rsvd && !fast_hit && (bus.req_op == OP_MUL);
         div_start <= accept && in_div && !fast_hit;
         unit_kill <= (state == S_WAIT) && (flush || timeout);

         if (accept) begin
            op_q          <= bus.req_op;
            word_q        <= bus.req_word;
            unit_a        <= prep_a;
            unit_b        <= prep_b;
            div_signed    <= in_signed;
            cnt           <= CNT_W'(1);
            bus.resp_err  <= 1'b0;
            bus.resp_data <= in_rsvd ? 64'd0 : fold(bus.req_word, fast_raw);
         end else if ((state == S_WAIT) && (state_nxt == S_WAIT)) begin
            cnt <= cnt + CNT_W'(1);
         end

         if (take) begin
            bus.resp_data <= fold(word_q, unit_raw);
            last_lat      <= (longint'(cnt) > LAT_MAX) ? {LAT_W{1'b1}} : LAT_W'(cnt);
         end

         if (timeout) begin
            bus.resp_data <= ALL_ONES;
            bus.resp_err  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: stimulus pushes hand-computed results into a scoreboard,
// a negedge monitor pops them on every response handshake; behavioural mul/div units respond.
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        reset, flush, stall;
   logic        mul_start, div_start, div_signed, div_done, unit_kill;
   logic        m_done = 1'b0, d_done = 1'b0, d_inj = 1'b0;
   logic [63:0] mul_result = 64'd0, div_quot = 64'd0, div_rem = 64'd0;
   logic [63:0] unit_a, unit_b;
   logic [7:0]  last_lat;

   int n_checks = 0, n_fail = 0;
   int n_ms = 0, n_ds = 0, n_kill = 0, n_rv = 0;
   int mul_lat = 0, div_lat = 0, mrem = 0, drem = 0;

   typedef struct {
      logic [63:0] data;
      logic        err;
      string       name;
   } exp_t;
   exp_t sb[$];

   muldiv_sched_if bus ();

   assign div_done = d_done | d_inj;

   muldiv_sched #(.MAX_CYCLES(10), .LAT_W(8)) dut (
      .clk(clk), .reset(reset), .flush(flush), .bus(bus), .stall(stall),
      .mul_start(mul_start), .mul_done(m_done), .mul_result(mul_result),
      .div_start(div_start), .div_signed(div_signed), .div_done(div_done),
      .div_quot(div_quot), .div_rem(div_rem), .unit_a(unit_a), .unit_b(unit_b),
      .unit_kill(unit_kill), .last_lat(last_lat)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      n_ms = 0; n_ds = 0; n_kill = 0; n_rv = 0;
   endtask

   // Behavioural units: done arrives in the lat-th cycle counting the start cycle as 1.
   always @(posedge clk) begin
      #1;
      m_done = 1'b0;
      if (unit_kill === 1'b1) mrem = 0;
      else if (mul_start === 1'b1) mrem = (mul_lat > 0) ? mul_lat - 1 : 0;
      else if (mrem > 0) begin
         mrem--;
         if (mrem == 0) begin
            m_done = 1'b1;
            mul_result = unit_a * unit_b;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      d_done = 1'b0;
      if (unit_kill === 1'b1) drem = 0;
      else if (div_start === 1'b1) drem = (div_lat > 0) ? div_lat - 1 : 0;
      else if (drem > 0) begin
         drem--;
         if (drem == 0) begin
            d_done = 1'b1;
            if (div_signed) begin
               div_quot = $signed(unit_a) / $signed(unit_b);
               div_rem  = $signed(unit_a) % $signed(unit_b);
            end else begin
               div_quot = unit_a / unit_b;
               div_rem  = unit_a % unit_b;
            end
         end
      end
   end

   // Monitor: pulse counters plus scoreboard comparison on each response handshake.
   always @(negedge clk) begin
      exp_t e;
      if (mul_start === 1'b1) n_ms++;
      if (div_start === 1'b1) n_ds++;
      if (unit_kill === 1'b1) n_kill++;
      if (bus.resp_valid === 1'b1) n_rv++;
      if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_resp: got data 0x%h with no expected entry", bus.resp_data);
         end else begin
            e = sb.pop_front();
            check({e.name, "_data"}, bus.resp_data, e.data);
            check({e.name, "_err"}, {63'd0, bus.resp_err}, {63'd0, e.err});
         end
      end
   end

   task automatic send(input string name, input logic [2:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, output bit ok);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_word  = word;
      bus.req_a     = a;
      bus.req_b     = b;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         #2;
         ok = bus.req_ready;
         tick();
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         bus.req_valid = 1'b0;
         $display("FAIL %s_accept: got req_ready low for 20 cycles, expected acceptance", name);
      end
   endtask

   // Issues one op, holds req_valid until the response handshake, and reports the number
   // of cycles from acceptance to the first resp_valid cycle.
   task automatic issue(input string name, input logic [2:0] op, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_d, input logic exp_e, input int bp,
                        output int lat);
      bit          ok, rv, rr, st, hs, st_bad, bp_bad;
      int          bp_seen;
      logic [63:0] held;
      lat = -1; hs = 0; st_bad = 0; bp_bad = 0; bp_seen = 0; held = 64'd0;
      bus.resp_ready = (bp == 0);
      send(name, op, word, a, b, ok);
      if (!ok) begin
         bus.resp_ready = 1'b1;
         return;
      end
      sb.push_back('{exp_d, exp_e, name});
      for (int c = 1; c <= 40 && !hs; c++) begin
         #2;
         rv = bus.resp_valid;
         rr = bus.resp_ready;
         st = stall;
         if (st !== (bus.req_valid && !(rv && rr))) st_bad = 1;
         if (rv) begin
            if (lat < 0) begin
               lat  = c;
               held = bus.resp_data;
            end
            if (!rr) begin
               bp_seen++;
               if (bus.resp_data !== held || bus.req_ready !== 1'b0 || st !== 1'b1) bp_bad = 1;
            end
         end
         hs = rv && rr;
         tick();
         if (rv && bp_seen >= bp) bus.resp_ready = 1'b1;
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      if (!hs) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_resp: got no handshake in 40 cycles, expected a response", name);
      end
      check({name, "_stall"}, {63'd0, st_bad}, 64'd0);
      if (bp > 0) begin
         check({name, "_bp_cycles"}, 64'(bp_seen), 64'(bp));
         check({name, "_bp_hold"}, {63'd0, bp_bad}, 64'd0);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no end of test, expected $finish");
      $fatal(1, "bench did not terminate");
   end

   initial begin
      int lat;
      bit ok;
      reset = 1'b1; flush = 1'b0;
      bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_word = 1'b0;
      bus.req_a = 64'd0; bus.req_b = 64'd0; bus.resp_ready = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      #2;
      check("rst_ctrl", {58'd0, bus.resp_valid, bus.resp_err, mul_start, div_start,
                         div_signed, unit_kill}, 64'd0);
      check("rst_data", bus.resp_data, 64'd0);
      check("rst_unit_ops", unit_a | unit_b, 64'd0);
      check("rst_last_lat", {56'd0, last_lat}, 64'd0);
      check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
      tick();

      // MUL 7*6, unit done in the 4th WAIT cycle.
      clr_counts(); mul_lat = 4;
      issue("mul_7x6", 3'd0, 1'b0, 64'd7, 64'd6, 64'd42, 1'b0, 0, lat);
      check("mul_lat", 64'(lat), 64'd5);
      check("mul_last_lat", {56'd0, last_lat}, 64'd4);
      check("mul_starts", {32'(n_ms), 32'(n_ds)}, {32'd1, 32'd0});

      // Word signed overflow and divide-by-zero fast paths.
      clr_counts();
      issue("divw_ovf", 3'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'hFFFF_FFFF_8000_0000, 1'b0, 0, lat);
      check("divw_ovf_lat", 64'(lat), 64'd1);
      issue("remw_ovf", 3'd3, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_FFFF_FFFF,
            64'd0, 1'b0, 0, lat);
      issue("remuw_dz", 3'd4, 1'b1, 64'h0000_0001_FFFF_FFF0, 64'h1234_5678_0000_0000,
            64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 0, lat);
      check("remuw_dz_lat", 64'(lat), 64'd1);
      issue("divu_dz", 3'd2, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, lat);
      issue("rsvd_op", 3'd5, 1'b0, 64'd9, 64'd9, 64'd0, 1'b0, 0, lat);
      check("rsvd_lat", 64'(lat), 64'd1);
      check("fast_starts", 64'(n_ms + n_ds), 64'd0);

      // Flush in the same cycle as a request: nothing accepted.
      clr_counts();
      bus.req_valid = 1'b1; bus.req_op = 3'd0; bus.req_a = 64'd2; bus.req_b = 64'd3;
      flush = 1'b1;
      #2;
      check("flush_req_ready", {63'd0, bus.req_ready}, 64'd0);
      tick();
      bus.req_valid = 1'b0; flush = 1'b0;
      repeat (3) tick();
      check("flush_req_ignored", 64'(n_ms + n_ds + n_rv), 64'd0);

      // DIV 100/7 flushed in its third WAIT cycle, then a late div_done.
      clr_counts(); div_lat = 0;
      send("div_flush", 3'd1, 1'b0, 64'd100, 64'd7, ok);
      bus.req_valid = 1'b0;
      #2;
      check("div_flush_signed", {63'd0, div_signed}, 64'd1);
      check("div_flush_unit_a", unit_a, 64'd100);
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #2;
      check("div_flush_kill_now", {63'd0, unit_kill}, 64'd1);
      tick();
      d_inj = 1'b1;
      tick();
      d_inj = 1'b0;
      repeat (3) tick();
      check("div_flush_kill_count", 64'(n_kill), 64'd1);
      check("div_flush_no_resp", 64'(n_rv), 64'd0);

      clr_counts(); div_lat = 5;
      issue("rem_100_7", 3'd3, 1'b0, 64'd100, 64'd7, 64'd2, 1'b0, 0, lat);
      check("rem_last_lat", {56'd0, last_lat}, 64'd5);
      check("rem_starts", {32'(n_ms), 32'(n_ds)}, {32'd0, 32'd1});

      // Word divides through the unit.
      div_lat = 3;
      issue("divw_unit", 3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
            64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 0, lat);
      issue("divuw_unit", 3'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
            64'h0000_0000_5555_554E, 1'b0, 0, lat);

      // Watchdog: divider never answers.
      clr_counts(); div_lat = 0;
      issue("watchdog", 3'd1, 1'b0, 64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0, lat);
      check("watchdog_lat", 64'(lat), 64'd11);
      check("watchdog_kill", 64'(n_kill), 64'd1);

      // Back-pressure: five DONE cycles without resp_ready.
      mul_lat = 3;
      issue("mul_bp", 3'd0, 1'b0, 64'd3, 64'd5, 64'd15, 1'b0, 5, lat);
      check("mul_bp_last_lat", {56'd0, last_lat}, 64'd3);

      // Reset in the middle of WAIT.
      div_lat = 0;
      send("div_rst", 3'd1, 1'b0, 64'd100, 64'd7, ok);
      bus.req_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      #2;
      check("wait_rst_ctrl", {58'd0, bus.resp_valid, bus.resp_err, mul_start, div_start,
                              div_signed, unit_kill}, 64'd0);
      check("wait_rst_data", bus.resp_data, 64'd0);
      check("wait_rst_unit_ops", unit_a | unit_b, 64'd0);
      check("wait_rst_last_lat", {56'd0, last_lat}, 64'd0);
      tick();
      reset = 1'b0;
      tick();
      #2;
      check("wait_rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
      tick();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
